// File: rtl/turn_scheduler.sv
// Two-player turn sequencer: deal, alternating turns,
// per-turn timeout, resolve and round counting.
module turn_scheduler #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ROUNDS         = 4,
  parameter int ROUND_W        = 3,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               p1_act,
  input  logic               p2_act,
  output logic [2:0]         state,
  output logic               p1_grant,
  output logic               p2_grant,
  output logic [ROUND_W-1:0] round,
  output logic               timeout,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    DEAL_P1   = 3'b001,
    DEAL_P2   = 3'b010,
    P1_TURN   = 3'b011,
    P2_TURN   = 3'b100,
    RESOLVE   = 3'b101,
    GAME_OVER = 3'b110
  } state_t;

  localparam logic [CNT_W-1:0] LP_TMAX =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ROUND_W-1:0] LP_RLAST =
    ROUND_W'(ROUNDS - 1);

  state_t             r_state;
  logic [ROUND_W-1:0] r_round;
  logic [CNT_W-1:0]   r_timer;
  logic               r_second;
  logic               r_timeout;

  logic w_act;
  logic w_tmax;
  logic w_end;

  // act from whichever player owns the turn; the other is ignored
  always_comb begin
    w_act  = 1'b0;
    w_tmax = (r_timer == LP_TMAX);
    unique case (1'b1)
      (r_state == P1_TURN): w_act = p1_act;
      (r_state == P2_TURN): w_act = p2_act;
      default:              w_act = 1'b0;
    endcase
    w_end = w_act | w_tmax;
  end

  // game sequencer; timer and timeout default to clear each cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_round   <= '0;
      r_timer   <= '0;
      r_second  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE, GAME_OVER: begin
          if (start) begin
            r_state <= DEAL_P1;
            r_round <= '0;
          end
        end
        DEAL_P1: r_state <= DEAL_P2;
        DEAL_P2: begin
          r_state  <= r_round[0] ? P2_TURN : P1_TURN;
          r_second <= 1'b0;
        end
        P1_TURN, P2_TURN: begin
          if (w_end) begin
            r_timeout <= ~w_act;
            if (r_second) begin
              r_state <= RESOLVE;
            end else begin
              r_second <= 1'b1;
              r_state  <= (r_state == P1_TURN) ?
                          P2_TURN : P1_TURN;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESOLVE: begin
          if (r_round == LP_RLAST) begin
            r_state <= GAME_OVER;
          end else begin
            r_state <= DEAL_P1;
            r_round <= r_round + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state    = r_state;
  assign p1_grant = (r_state == P1_TURN);
  assign p2_grant = (r_state == P2_TURN);
  assign round    = r_round;
  assign timeout  = r_timeout;
  assign done     = (r_state == GAME_OVER);

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed game script then
// random play, compared against a behavioural game model.
module tb_turn_scheduler;

  localparam int T  = 16;
  localparam int R  = 4;
  localparam int RW = 3;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          p1_act = 1'b0;
  logic          p2_act = 1'b0;
  logic [2:0]    state;
  logic          p1_grant;
  logic          p2_grant;
  logic [RW-1:0] round;
  logic          timeout;
  logic          done;

  int checks = 0;
  int failures = 0;

  // model: phase names, current round, turn age, turns taken
  localparam int S_IDLE = 0, S_D1 = 1, S_D2 = 2;
  localparam int S_P1 = 3, S_P2 = 4, S_RES = 5, S_OVER = 6;
  int m_ph = S_IDLE;
  int m_rnd = 0;
  int m_age = 0;
  int m_turns = 0;
  int m_to = 0;

  turn_scheduler #(
    .TIMEOUT_CYCLES(T), .ROUNDS(R),
    .ROUND_W(RW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .p1_act(p1_act), .p2_act(p2_act),
    .state(state), .p1_grant(p1_grant),
    .p2_grant(p2_grant), .round(round),
    .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // advance the game model by one clock of sampled inputs
  task automatic model(input bit r, input bit s,
                       input bit a1, input bit a2);
    bit own;
    if (!r) begin
      m_ph = S_IDLE; m_rnd = 0; m_age = 0;
      m_turns = 0; m_to = 0;
      return;
    end
    m_to = 0;
    case (m_ph)
      S_IDLE, S_OVER:
        if (s) begin m_ph = S_D1; m_rnd = 0; end
      S_D1: m_ph = S_D2;
      S_D2: begin
        m_ph = (m_rnd % 2 == 0) ? S_P1 : S_P2;
        m_turns = 0;
        m_age = 0;
      end
      S_P1, S_P2: begin
        own = (m_ph == S_P1) ? a1 : a2;
        m_age++;
        if (own || m_age >= T) begin
          m_to = own ? 0 : 1;
          m_turns++;
          m_age = 0;
          m_ph = (m_turns == 2) ? S_RES : (S_P1 + S_P2 - m_ph);
        end
      end
      S_RES:
        if (m_rnd == R - 1) m_ph = S_OVER;
        else begin m_ph = S_D1; m_rnd++; end
      default: m_ph = S_IDLE;
    endcase
  endtask

  task automatic step(input bit r, input bit s,
                      input bit a1, input bit a2);
    rst_n = r; start = s; p1_act = a1; p2_act = a2;
    @(posedge clk);
    model(r, s, a1, a2);
    #1;
    chk("state", 8'(state), 8'(m_ph));
    chk("p1_grant", 8'(p1_grant), 8'(m_ph == S_P1));
    chk("p2_grant", 8'(p2_grant), 8'(m_ph == S_P2));
    chk("round", 8'(round), 8'(m_rnd));
    chk("timeout", 8'(timeout), 8'(m_to));
    chk("done", 8'(done), 8'(m_ph == S_OVER));
  endtask

  initial begin
    // reset, idle without start
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    // round 0: P1 first, act on 3rd turn cycle
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    // round 1: P2 first, held p1_act ignored
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    // round 2: acts in deal ignored, both turns time out
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (T) step(1, 0, 0, 0);
    repeat (T) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // round 3: acts collide with the timeout cycle
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (T - 1) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (T - 1) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    // game over holds, then restart skips idle
    repeat (10) step(1, 0, 1, 1);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    // reset in the middle of a P2 turn
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    // random play
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(199) != 0,
           $urandom_range(7) == 0,
           $urandom_range(5) == 0,
           $urandom_range(5) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
